// File: rtl/ofifo_if.sv
// ---------------------------------------------------------------------------
// ofifo_if
// Bundles the data and handshake signals between the MAC array south edge,
// the corelet FSM and the output FIFO (ofifo).
//
// Signals (lane c of a row occupies bits [c*psum_bw +: psum_bw]):
//   in      column data from the MAC array
//   wr      per-column write strobe (mac_array valid)
//   rd      pop one complete row from every column
//   out     registered row data, same lane packing as in
//   o_full  at least one column queue is full
//   o_ready every column can accept a write
//   o_valid every column queue holds at least one entry
//   o_err   sticky protocol-error flag
//
// Modports:
//   master  the side that produces writes and reads (array + corelet)
//   slave   the FIFO itself
// ---------------------------------------------------------------------------
interface ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);

  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_valid;
  logic                   o_err;

  modport master (
    output in,
    output wr,
    output rd,
    input  out,
    input  o_full,
    input  o_ready,
    input  o_valid,
    input  o_err
  );

  modport slave (
    input  in,
    input  wr,
    input  rd,
    output out,
    output o_full,
    output o_ready,
    output o_valid,
    output o_err
  );

endinterface

// File: rtl/ofifo.sv
// ---------------------------------------------------------------------------
// ofifo
// Output FIFO at the south edge of the MAC array. Each column has its own
// queue and write strobe because columns finish at different cycles in the
// skewed systolic wavefront. A row is readable only once every column holds
// at least one entry; a read pops one entry from every column at once and
// registers the row onto out.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   reset  synchronous, active-low
//   bus    ofifo_if.slave (in, wr, rd, out, o_full, o_ready, o_valid, o_err)
//
// Parameters:
//   col      number of array columns (independent queues)
//   psum_bw  width of one partial sum
//   depth    entries per column queue (power of two, >= 2)
//
// Optional feature:
//   OFIFO_ERR_EN  when defined, o_err latches on a write to a full column or
//                 on rd while o_valid is low; otherwise o_err is tied low.
// ---------------------------------------------------------------------------
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic        clk,
  input  logic        reset,
  ofifo_if.slave      bus
);

  localparam int aw = $clog2(depth);

  logic [col-1:0]         col_full;
  logic [col-1:0]         col_empty;
  logic [col*psum_bw-1:0] head;
  logic [col*psum_bw-1:0] out_q;
  logic                   row_valid;
  logic                   rd_fire;

  // A row exists only when no column is empty; the read is accepted on the
  // same pre-edge view, so a read into an empty column is simply blocked.
  assign row_valid = ~|col_empty;
  assign rd_fire   = bus.rd & row_valid;

  for (genvar c = 0; c < col; c++) begin : g_col

    logic [psum_bw-1:0] mem [depth];
    logic [aw:0]        wptr;
    logic [aw:0]        rptr;
    logic               wr_fire;

    // The extra pointer MSB distinguishes a full queue (low bits equal, MSBs
    // differ) from an empty one (pointers identical).
    assign col_empty[c] = (wptr == rptr);
    assign col_full[c]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);

    // Write acceptance uses the pre-edge full flag, so a write into a full
    // column is dropped even if a read frees a slot on the same edge.
    assign wr_fire = bus.wr[c] & ~col_full[c];

    // Storage has no reset so it can map onto plain RAM; after reset the old
    // contents are unreachable because the pointers restart at zero.
    always_ff @(posedge clk) begin
      if (reset && wr_fire) begin
        mem[wptr[aw-1:0]] <= bus.in[c*psum_bw +: psum_bw];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_fire) begin
          wptr <= wptr + 1'b1;
        end
        if (rd_fire) begin
          rptr <= rptr + 1'b1;
        end
      end
    end

    assign head[c*psum_bw +: psum_bw] = mem[rptr[aw-1:0]];

  end

  // Output row register: holds its value until the next accepted read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
    end else if (rd_fire) begin
      out_q <= head;
    end
  end

  assign bus.out     = out_q;
  assign bus.o_full  = |col_full;
  assign bus.o_ready = ~(|col_full);
  assign bus.o_valid = row_valid;

`ifdef OFIFO_ERR_EN
  logic err_q;

  // Sticky until reset; the offending operation itself is still dropped or
  // ignored by the datapath above.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((|(bus.wr & col_full)) || (bus.rd && !row_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo.sv
// ---------------------------------------------------------------------------
// tb_ofifo
// Directed bench for ofifo (col=8, psum_bw=16, depth=64). A per-column
// queue model holds the expected contents; writes push into it when driven
// and accepted reads pop a full row that becomes the expected out value.
// Compile with +define+OFIFO_ERR_EN to expect the error flag behaviour.
// ---------------------------------------------------------------------------
module tb_ofifo;

  localparam int n_col = 8;
  localparam int pbw   = 16;
  localparam int dep   = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ofifo_if #(.col(n_col), .psum_bw(pbw)) bus ();

  ofifo #(.col(n_col), .psum_bw(pbw), .depth(dep)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [pbw-1:0]       sb [n_col][$];
  logic [n_col*pbw-1:0] exp_out;
  logic                 exp_err;
  int                   tests_run;
  int                   tests_failed;

  // Build a row whose lanes are all distinct: {tag, column, index}.
  function automatic logic [n_col*pbw-1:0] mk_row(input int idx, input int tag);
    logic [n_col*pbw-1:0] r;
    r = '0;
    for (int c = 0; c < n_col; c++) begin
      r[c*pbw +: pbw] = 16'(((tag & 15) << 12) | (c << 8) | (idx & 255));
    end
    return r;
  endfunction

  function automatic logic [n_col*pbw-1:0] rand_row();
    logic [n_col*pbw-1:0] r;
    for (int c = 0; c < n_col; c++) begin
      r[c*pbw +: pbw] = 16'($urandom_range(0, 65535));
    end
    return r;
  endfunction

  // Drive one clock of stimulus and update the model from the pre-edge view.
  task automatic applyStimulus(input logic [n_col-1:0] w, input logic [n_col*pbw-1:0] d,
                               input logic r, input logic rst_n);
    logic             pre_valid;
    logic [n_col-1:0] pre_full;
    pre_valid = 1'b1;
    for (int c = 0; c < n_col; c++) begin
      if (sb[c].size() == 0) pre_valid = 1'b0;
      pre_full[c] = (sb[c].size() == dep);
    end
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    reset  = rst_n;
    if (!rst_n) begin
      for (int c = 0; c < n_col; c++) sb[c].delete();
      exp_out = '0;
      exp_err = 1'b0;
    end else begin
      if (((w & pre_full) != '0) || (r && !pre_valid)) exp_err = 1'b1;
      if (r && pre_valid) begin
        for (int c = 0; c < n_col; c++) exp_out[c*pbw +: pbw] = sb[c].pop_front();
      end
      for (int c = 0; c < n_col; c++) begin
        if (w[c] && !pre_full[c]) sb[c].push_back(d[c*pbw +: pbw]);
      end
    end
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
    reset  = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    logic e_valid;
    logic e_full;
    logic e_err;
    e_valid = 1'b1;
    e_full  = 1'b0;
    for (int c = 0; c < n_col; c++) begin
      if (sb[c].size() == 0) e_valid = 1'b0;
      if (sb[c].size() == dep) e_full = 1'b1;
    end
`ifdef OFIFO_ERR_EN
    e_err = exp_err;
`else
    e_err = 1'b0;
`endif
    tests_run++;
    assert (bus.o_valid === e_valid) else begin
      tests_failed++;
      $error("[TB] FAIL %s o_valid: got %b expected %b", tag, bus.o_valid, e_valid);
    end
    tests_run++;
    assert (bus.o_full === e_full) else begin
      tests_failed++;
      $error("[TB] FAIL %s o_full: got %b expected %b", tag, bus.o_full, e_full);
    end
    tests_run++;
    assert (bus.o_ready === ~e_full) else begin
      tests_failed++;
      $error("[TB] FAIL %s o_ready: got %b expected %b", tag, bus.o_ready, ~e_full);
    end
    tests_run++;
    assert (bus.o_err === e_err) else begin
      tests_failed++;
      $error("[TB] FAIL %s o_err: got %b expected %b", tag, bus.o_err, e_err);
    end
    tests_run++;
    assert (bus.out === exp_out) else begin
      tests_failed++;
      $error("[TB] FAIL %s out: got %h expected %h", tag, bus.out, exp_out);
    end
  endtask

  initial begin
    logic [n_col*pbw-1:0] d;
    logic [n_col*pbw-1:0] skew_row;
    tests_run    = 0;
    tests_failed = 0;
    exp_out      = '0;
    exp_err      = 1'b0;
    bus.in       = '0;
    bus.wr       = '0;
    bus.rd       = 1'b0;
    reset        = 1'b0;

    // Reset with wr/rd asserted: both must be ignored.
    applyStimulus('1, mk_row(0, 1), 1'b1, 1'b0);
    checkOutput("reset");

    // Skewed fill: column c written at cycle c.
    for (int c = 0; c < n_col; c++) begin
      d = '0;
      d[c*pbw +: pbw] = 16'(16'h0100 + c);
      applyStimulus(8'(1 << c), d, 1'b0, 1'b1);
      checkOutput("skew_fill");
    end
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("skew_read");
    skew_row = {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                16'h0103, 16'h0102, 16'h0101, 16'h0100};
    tests_run++;
    assert (bus.out === skew_row) else begin
      tests_failed++;
      $error("[TB] FAIL skew_lanes out: got %h expected %h", bus.out, skew_row);
    end

    // Full boundary: 64 writes, dropped 65th, then 64 ordered reads.
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < dep; i++) begin
      applyStimulus('1, mk_row(i, 2), 1'b0, 1'b1);
      checkOutput("full_fill");
    end
    applyStimulus('1, {n_col{16'hDEAD}}, 1'b0, 1'b1);
    checkOutput("full_drop");
    for (int i = 0; i < dep; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("full_drain");
    end

    // Read while empty: out and pointers must hold.
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('1, mk_row(5, 4), 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("pre_empty_read");
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("rd_empty");
    applyStimulus('1, mk_row(6, 4), 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("rd_empty_after");

    // Wrap-around at steady occupancy 3.
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('1, rand_row(), 1'b0, 1'b1);
    checkOutput("wrap_prefill");
    for (int i = 0; i < 200; i++) begin
      applyStimulus('1, rand_row(), 1'b1, 1'b1);
      checkOutput("wrap");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("wrap_drain");
    end

    // Simultaneous rd and wr with every column full.
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < dep; i++) applyStimulus('1, mk_row(i, 6), 1'b0, 1'b1);
    checkOutput("rdwr_full_pre");
    applyStimulus('1, {n_col{16'hBEEF}}, 1'b1, 1'b1);
    checkOutput("rdwr_full");
    for (int i = 0; i < dep - 1; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("rdwr_full_drain");
    end

    // Simultaneous rd and wr at occupancy 10.
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus('1, mk_row(i, 7), 1'b0, 1'b1);
    applyStimulus('1, mk_row(99, 8), 1'b1, 1'b1);
    checkOutput("rdwr_10");
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("rdwr_10_drain");
    end

    // Simultaneous rd and wr on empty columns: write lands, read blocked.
    applyStimulus('0, '0, 1'b0, 1'b0);
    applyStimulus('1, mk_row(3, 9), 1'b1, 1'b1);
    checkOutput("rdwr_empty");
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("rdwr_empty_read");

    // Reset mid-stream with 5 rows queued.
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus('1, mk_row(i, 10), 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("mid_pre");
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("mid_reset");
    applyStimulus('1, mk_row(42, 11), 1'b0, 1'b1);
    checkOutput("mid_write");
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("mid_fresh");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO at the south edge of the MAC array: it collects the per-column partial-sum stream (`out_s`/`valid`) and hands complete rows to the corelet FSM, which writes them into the OP SRAM over `OP_d`. Each column has its own queue and write strobe, because columns finish at different cycles in the skewed systolic wavefront. A row becomes readable only when every column holds at least one entry, and a read pops one entry from every column at once.

## Interface
- `col`, 8: number of array columns (independent queues).
- `psum_bw`, 16: width of one partial sum.
- `depth`, 64: entries per column queue; power of two, ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `in`  in  col*psum_bw  column data; column c occupies bits [c*psum_bw +: psum_bw].
- `wr`  in  col  per-column write strobe (driven by mac_array `valid`).
- `rd`  in  1  pop one row from all columns.
- `out`  out  col*psum_bw  registered row data, same lane packing as `in`.
- `o_full`  out  1  at least one column queue is full.
- `o_ready`  out  1  `~o_full`: every column can accept a write.
- `o_valid`  out  1  every column queue is non-empty.
- `o_err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Per column c: storage array of depth × psum_bw; write pointer and read pointer, each log2(depth)+1 bits. The extra MSB separates full from empty.
- Column empty: pointers are equal. Column full: low bits are equal and the MSBs differ. Pointers wrap naturally at 2·depth.
- Write:
  - `wr[c]=1` and column c not full → store `in[c]` at `wptr[c]`, then increment `wptr[c]`.
  - `wr[c]=1` with column c full → write dropped for that column only; other columns still write.
- Read:
  - `rd=1` and `o_valid=1` → every column's head is copied into `out`, and every `rptr` increments.
  - `rd=1` with `o_valid=0` → ignored; `out` and pointers unchanged.
- Simultaneous write and read on the same column: both take effect and occupancy is unchanged.
  - Full column: the read frees a slot in the same edge, but write acceptance uses the pre-edge state, so the write is still dropped.
  - Empty column: the read is blocked because `o_valid` is computed from pre-edge state; the write is accepted.
- Flags `o_full`, `o_ready`, `o_valid` are combinational from the pointers. They reflect state after the most recent edge.
- `out` holds its last value until the next accepted read.
- Reset (`reset=0` at an edge), including mid-operation:
  - All pointers cleared, `out=0`, `o_err=0`.
  - Stored data is not cleared and is unreachable.
  - After reset: `o_full=0`, `o_ready=1`, `o_valid=0`.
  - `wr` and `rd` are ignored during the reset edge.

## Timing
- Write latency:
  - A write at edge k makes the entry visible to flags after edge k.
  - If it completes the row, `o_valid=1` in cycle k+1.
- Read latency: `rd` accepted at edge k → `out` carries that row from edge k onward (one registered stage).
- Throughput: one row read per cycle, and one write per column per cycle, sustained concurrently.
- No combinational path from `rd` or `wr` to any output.

## Configuration
- `OFIFO_ERR_EN` defined:
  - `o_err` is set, and stays set until reset, on a write to a full column or on `rd=1` while `o_valid=0`.
  - The offending operation is still dropped or ignored as described in Operation.
- `OFIFO_ERR_EN` undefined: `o_err` is tied to 0 and no error logic is synthesized. Data behaviour is identical.

## Test plan
- Reset then skewed fill (col=8, depth=64):
  - Stimulus: write column c with value 16'h0100+c starting at cycle c.
  - Required: `o_valid` stays 0 until the cycle after column 7's write, then goes to 1.
  - Required: `rd` yields `out` lanes 0..7 = 16'h0100..16'h0107.
- Full boundary:
  - Stimulus: 64 writes to all columns, then a 65th write of 16'hDEAD.
  - Required: `o_full=1` and `o_ready=0` after the 64th write.
  - Required: the 65th write is dropped; `o_err=1` when `OFIFO_ERR_EN` is defined, 0 otherwise.
  - Required: 64 reads return the original data, in order.
- Wrap-around:
  - Stimulus: 200 interleaved write/read cycles at a steady occupancy of 3.
  - Required: data is returned in order across pointer wrap; no spurious full or empty.
- Simultaneous read and write on a full column:
  - Stimulus: `rd` and `wr` asserted together with every column full.
  - Required: occupancy drops to 63 and the write is dropped.
  - Stimulus: repeat with occupancy 10.
  - Required: occupancy stays 10 and the data order is preserved.
- Read while empty:
  - Stimulus: `rd=1` with `o_valid=0`.
  - Required: `out` is unchanged and pointers are unchanged; `o_err=1` when `OFIFO_ERR_EN` is defined.
- Reset mid-stream:
  - Stimulus: assert `reset=0` with 5 rows queued.
  - Required, next cycle: `o_valid=0`, `o_full=0`, `out=0`, `o_err=0`.
  - Required: the next write/read pair returns fresh data only.
